// File: rtl/ring_load_sequencer_if.sv
// Upstream word handshake for the ring load sequencer.
// The master offers a word, and the slave accepts it when in_ready is high.
interface ring_load_sequencer_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/ring_load_sequencer.sv
// Serial feeder for a right-rotating ring register: accepts a word, then drives
// ld/in_bit LSB-first for WIDTH cycles and pulses done. Optional: RLS_ABORT_EN.
module ring_load_sequencer #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
`ifdef RLS_ABORT_EN
    input  logic abort_i,
`endif
    ring_load_sequencer_if.slave up_if,
    output logic ld_o,
    output logic in_bit_o,
    output logic busy_o,
    output logic done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               ld_q;
    logic               bit_q;
    logic               busy_q;
    logic               done_q;

    // Outputs are registered alongside the next state so they never see in_*
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            ld_q    <= 1'b0;
            bit_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            ld_q    <= 1'b0;
            bit_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (up_if.in_valid && ready_q) begin
                        state_q <= SHIFT;
                        shreg_q <= up_if.in_data;
                        cnt_q   <= '0;
                        ld_q    <= 1'b1;
                        bit_q   <= up_if.in_data[0];
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
`ifdef RLS_ABORT_EN
                    if (abort_i) begin
                        state_q <= IDLE;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else
`endif
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        ld_q    <= 1'b1;
                        bit_q   <= shreg_q[1];
                        busy_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign up_if.in_ready = ready_q;
    assign ld_o           = ld_q;
    assign in_bit_o       = bit_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule
